// File: rtl/io_input_port.sv
// Switch-bank responder for the IO read path: 2-flop sync, whole-word debounce, sticky new-data flag.
// Latency: DEBOUNCE_CYCLES+3 edges from a clean sw_in change to InputData. No backpressure; rd_strobe only clears data_valid.
// Optional IO_INPUT_IRQ_EN adds irq_mask/irq (registered data_valid & irq_mask).
module io_input_port #(
    parameter int DATA_WIDTH      = 16,
    parameter int CNT_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] sw_in,
    input  logic                  rd_strobe,
    output logic [DATA_WIDTH-1:0] InputData,
    output logic                  data_valid,
    output logic                  change_pulse
`ifdef IO_INPUT_IRQ_EN
    ,
    input  logic                  irq_mask,
    output logic                  irq
`endif
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sync1_q, sync2_q;
    logic [DATA_WIDTH-1:0] cand_q, cand_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  pulse_q;
    logic                  commit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync2_q != data_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (sync2_q == cand_q) begin
                    if (cnt_q == LAST_CNT) begin
                        data_d  = cand_q;
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sync2_q == data_q) begin
                    state_d = IDLE;
                end else begin
                    // any bit moving restarts the whole-word count
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // a commit beats a coincident read so fresh data is never lost
    always_comb begin
        valid_d = valid_q;
        if (commit) begin
            valid_d = 1'b1;
        end else if (rd_strobe) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pulse_q <= commit;
        end
    end

    assign InputData    = data_q;
    assign data_valid   = valid_q;
    assign change_pulse = pulse_q;

`ifdef IO_INPUT_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= valid_d & irq_mask;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port with DEBOUNCE_CYCLES=4: vector table plus hand-written corner sequences.
module tb_io_input_port;

    logic        clk;
    logic        reset_n;
    logic [15:0] sw_in;
    logic        rd_strobe;
    logic [15:0] InputData;
    logic        data_valid;
    logic        change_pulse;
`ifdef IO_INPUT_IRQ_EN
    logic        irq_mask;
    logic        irq;
`endif

    int nvec = 0;
    int nerr = 0;

    io_input_port #(
        .DATA_WIDTH     (16),
        .CNT_WIDTH      (16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw_in       (sw_in),
        .rd_strobe   (rd_strobe),
        .InputData   (InputData),
        .data_valid  (data_valid),
        .change_pulse(change_pulse)
`ifdef IO_INPUT_IRQ_EN
        ,
        .irq_mask    (irq_mask),
        .irq         (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sw;
        logic        rd;
        logic [15:0] exp_data;
        logic        exp_dv;
        logic        exp_cp;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [15:0] d, input logic dv, input logic cp);
        nvec++;
        if (InputData !== d || data_valid !== dv || change_pulse !== cp) begin
            nerr++;
            $display("FAIL %s: got data=%h dv=%b cp=%b, expected data=%h dv=%b cp=%b",
                     name, InputData, data_valid, change_pulse, d, dv, cp);
        end
`ifdef IO_INPUT_IRQ_EN
        nvec++;
        if (irq !== dv) begin
            nerr++;
            $display("FAIL %s irq: got %b, expected %b", name, irq, dv);
        end
`endif
    endtask

    // one clock: inputs already set at a negedge, sampled at posedge, checked at next negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] sw);
        @(negedge clk);
        reset_n   = 1'b0;
        sw_in     = sw;
        rd_strobe = 1'b0;
        #1;
        check("reset_async", 16'h0000, 1'b0, 1'b0);
        step();
        step();
        check("reset_hold", 16'h0000, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        nerr++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        logic saw_bad;

        reset_n   = 1'b0;
        sw_in     = 16'h0000;
        rd_strobe = 1'b0;
`ifdef IO_INPUT_IRQ_EN
        irq_mask  = 1'b1;
`endif

        // Clean change, read clear, read while clear, commit/read collision.
        vecs[0]  = '{16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{16'h1234, 1'b0, 16'h1234, 1'b1, 1'b1};
        vecs[7]  = '{16'h1234, 1'b0, 16'h1234, 1'b1, 1'b0};
        vecs[8]  = '{16'h1234, 1'b1, 16'h1234, 1'b0, 1'b0};
        vecs[9]  = '{16'h1234, 1'b1, 16'h1234, 1'b0, 1'b0};
        vecs[10] = '{16'h00FF, 1'b0, 16'h1234, 1'b0, 1'b0};
        vecs[11] = '{16'h00FF, 1'b0, 16'h1234, 1'b0, 1'b0};
        vecs[12] = '{16'h00FF, 1'b0, 16'h1234, 1'b0, 1'b0};
        vecs[13] = '{16'h00FF, 1'b0, 16'h1234, 1'b0, 1'b0};
        vecs[14] = '{16'h00FF, 1'b0, 16'h1234, 1'b0, 1'b0};
        vecs[15] = '{16'h00FF, 1'b0, 16'h1234, 1'b0, 1'b0};
        vecs[16] = '{16'h00FF, 1'b1, 16'h00FF, 1'b1, 1'b1};
        vecs[17] = '{16'h00FF, 1'b0, 16'h00FF, 1'b1, 1'b0};

        // Reset with switches at A5A5: nothing commits before edge 7 after release.
        do_reset(16'hA5A5);
        for (int e = 1; e <= 6; e++) begin
            step();
            check("reset_release_wait", 16'h0000, 1'b0, 1'b0);
        end
        step();
        check("reset_first_commit", 16'hA5A5, 1'b1, 1'b1);

        // Table-driven section starting from a settled zero word.
        do_reset(16'h0000);
        for (int i = 0; i < 4; i++) begin
            step();
            check("settle_zero", 16'h0000, 1'b0, 1'b0);
        end
        for (int i = 0; i < 18; i++) begin
            sw_in     = vecs[i].sw;
            rd_strobe = vecs[i].rd;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_dv, vecs[i].exp_cp);
        end
        rd_strobe = 1'b0;

        // Bounce rejection: 2-cycle toggles never reach a full count.
        do_reset(16'h0000);
        for (int k = 0; k < 30; k++) begin
            sw_in = (k < 20 && ((k / 2) % 2 == 0)) ? 16'h0001 : 16'h0000;
            step();
            check("bounce_reject", 16'h0000, 1'b0, 1'b0);
        end

        // Bounce then settle: 0x0001 for 2 cycles, then 0x0003 commits once at edge 9.
        pulses  = 0;
        saw_bad = 1'b0;
        for (int k = 0; k < 14; k++) begin
            sw_in = (k < 2) ? 16'h0001 : 16'h0003;
            step();
            if (change_pulse) pulses++;
            if (InputData == 16'h0001) saw_bad = 1'b1;
            if (k == 7) check("settle_before_commit", 16'h0000, 1'b0, 1'b0);
            if (k == 8) check("settle_commit", 16'h0003, 1'b1, 1'b1);
        end
        nvec++;
        if (pulses != 1 || saw_bad) begin
            nerr++;
            $display("FAIL settle_once: got pulses=%0d saw_0001=%b, expected pulses=1 saw_0001=0", pulses, saw_bad);
        end

        // Reset mid-debounce (counter=2) discards the candidate; full debounce restarts.
        do_reset(16'h0000);
        for (int i = 0; i < 3; i++) step();
        sw_in = 16'h0F0F;
        for (int e = 1; e <= 5; e++) begin
            step();
            check("mid_pre_reset", 16'h0000, 1'b0, 1'b0);
        end
        reset_n = 1'b0;
        #1;
        check("mid_reset_async", 16'h0000, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            check("mid_restart_wait", 16'h0000, 1'b0, 1'b0);
        end
        step();
        check("mid_restart_commit", 16'h0F0F, 1'b1, 1'b1);
        step();
        check("mid_hold", 16'h0F0F, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
